// File: rtl/pipeline_fork.sv
// ---------------------------------------------------------------------------
// pipeline_fork
//   Latency-insensitive fork that broadcasts one valid/bp token stream to
//   NumOut independent consumers. A per-output done mask remembers which
//   consumers have already taken the current token, so each consumer sees
//   each token exactly once. The producer is released (d_bp low) only in the
//   cycle where the last outstanding consumer takes the token.
//
//   Intended to sit directly after a registered pipeline stage: the path
//   q_bp -> d_bp is combinational, so the upstream stage must be registered
//   to avoid a combinational loop.
//
// Parameters
//   Width    data bits per token
//   NumOut   number of consumer ports (>= 1)
//
// Ports
//   clk      in   1       clock, all state updates on posedge
//   resetn   in   1       synchronous active-low reset
//   d        in   Width   input token data (held stable while d_valid && d_bp)
//   d_valid  in   1       input token present
//   d_bp     out  1       backpressure to producer
//   q        out  Width   broadcast data, equal to d
//   q_valid  out  NumOut  per-consumer token present
//   q_bp     in   NumOut  per-consumer backpressure
// ---------------------------------------------------------------------------
module pipeline_fork #(
  parameter int Width  = 8,
  parameter int NumOut = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [Width-1:0]  d,
  input  logic              d_valid,
  output logic              d_bp,
  output logic [Width-1:0]  q,
  output logic [NumOut-1:0] q_valid,
  input  logic [NumOut-1:0] q_bp
);

  logic [NumOut-1:0] done;
  logic [NumOut-1:0] accept;
  logic              all_taken;

  // Offer the token only to consumers that have not yet taken it. The token
  // is fully delivered once every consumer either took it earlier or takes
  // it right now; only then is the producer allowed to move on.
  always_comb begin
    q         = d;
    q_valid   = {NumOut{d_valid}} & ~done;
    accept    = q_valid & ~q_bp;
    all_taken = &(done | accept);
    d_bp      = d_valid & ~all_taken;
  end

  // The done mask clears in the cycle the token retires so the next token is
  // offered to every consumer in the following cycle. With no token present
  // accept is all-zero, so the mask simply holds.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      done <= '0;
    end else if (d_valid && all_taken) begin
      done <= '0;
    end else begin
      done <= done | accept;
    end
  end

`ifndef SYNTHESIS
  // Dropping d_valid while some consumers already took the token would leave
  // the remaining consumers without it; flag it so the producer bug is seen.
  always_ff @(posedge clk) begin
    if (resetn && !d_valid && (done != '0)) begin
      $display("[pipeline_fork] warning %m: d_valid dropped with done=%b at %0t",
               done, $time);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fork.sv
// ---------------------------------------------------------------------------
// tb_pipeline_fork
//   Self-checking bench for pipeline_fork with three instances:
//     dut2  NumOut=2  table of per-cycle vectors covering back-to-back
//                     streaming, partial acceptance, alternating
//                     backpressure and reset in the middle of a token
//     dut4  NumOut=4  random backpressure, 1000 tokens, per-output
//                     scoreboard queues (order, drops, duplicates)
//     dut1  NumOut=1  degenerate wire behaviour under random inputs
//   Inputs change on the falling edge; outputs are sampled 1 time unit later,
//   well away from the rising edge that updates the done mask.
// ---------------------------------------------------------------------------
module tb_pipeline_fork;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut2 signals
  logic       rstn2 = 1'b0;
  logic [7:0] d2    = '0;
  logic       dv2   = 1'b0;
  logic       db2;
  logic [7:0] q2;
  logic [1:0] qv2;
  logic [1:0] qbp2  = '0;

  // dut4 / dut1 share a reset
  logic       rstn_b = 1'b0;

  logic [7:0] d4   = '0;
  logic       dv4  = 1'b0;
  logic       db4;
  logic [7:0] q4;
  logic [3:0] qv4;
  logic [3:0] qbp4 = '0;

  logic [7:0] d1   = '0;
  logic       dv1  = 1'b0;
  logic       db1;
  logic [7:0] q1;
  logic [0:0] qv1;
  logic [0:0] qbp1 = '0;

  pipeline_fork #(.Width(8), .NumOut(2)) dut2 (
    .clk(clk), .resetn(rstn2), .d(d2), .d_valid(dv2), .d_bp(db2),
    .q(q2), .q_valid(qv2), .q_bp(qbp2)
  );

  pipeline_fork #(.Width(8), .NumOut(4)) dut4 (
    .clk(clk), .resetn(rstn_b), .d(d4), .d_valid(dv4), .d_bp(db4),
    .q(q4), .q_valid(qv4), .q_bp(qbp4)
  );

  pipeline_fork #(.Width(8), .NumOut(1)) dut1 (
    .clk(clk), .resetn(rstn_b), .d(d1), .d_valid(dv1), .d_bp(db1),
    .q(q1), .q_valid(qv1), .q_bp(qbp1)
  );

  // One cycle of dut2 stimulus together with the outputs it must produce
  typedef struct packed {
    logic       rstn;
    logic [7:0] d;
    logic       dv;
    logic [1:0] bp;
    logic [1:0] qv;
    logic       dbp;
  } vec_t;

  vec_t vecs[$];

  // Expected tokens per dut4 output, pushed when the token is first offered
  logic [7:0] exp4[4][$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rstn2 = v.rstn;
    d2    = v.d;
    dv2   = v.dv;
    qbp2  = v.bp;
  endtask

  initial begin
    // ---------------- dut2 vector table ----------------
    //                 rstn  d      dv    bp     qv     dbp
    vecs.push_back('{1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0}); // idle in reset
    vecs.push_back('{1'b0, 8'h99, 1'b1, 2'b11, 2'b11, 1'b1}); // reset: d_bp = dv & |bp
    vecs.push_back('{1'b1, 8'h00, 1'b0, 2'b11, 2'b00, 1'b0}); // idle ignores q_bp
    vecs.push_back('{1'b1, 8'h11, 1'b1, 2'b00, 2'b11, 1'b0}); // back-to-back stream
    vecs.push_back('{1'b1, 8'h22, 1'b1, 2'b00, 2'b11, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 1'b1, 2'b00, 2'b11, 1'b0});
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 2'b10, 2'b11, 1'b1}); // out0 takes c0
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 2'b10, 2'b10, 1'b1}); // out0 no longer offered
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 2'b10, 2'b10, 1'b1});
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 2'b00, 2'b10, 1'b0}); // out1 takes, retire
    vecs.push_back('{1'b1, 8'h5A, 1'b1, 2'b01, 2'b11, 1'b1}); // out1 takes c0
    vecs.push_back('{1'b1, 8'h5A, 1'b1, 2'b10, 2'b01, 1'b0}); // out0 takes, retire
    vecs.push_back('{1'b1, 8'h66, 1'b1, 2'b11, 2'b11, 1'b1}); // next token to both
    vecs.push_back('{1'b1, 8'h66, 1'b1, 2'b00, 2'b11, 1'b0});
    vecs.push_back('{1'b1, 8'h7E, 1'b1, 2'b10, 2'b11, 1'b1}); // out0 takes 7E
    vecs.push_back('{1'b1, 8'h7E, 1'b1, 2'b10, 2'b10, 1'b1}); // done = 01
    vecs.push_back('{1'b0, 8'h7E, 1'b1, 2'b11, 2'b10, 1'b1}); // reset mid-token
    vecs.push_back('{1'b1, 8'h7E, 1'b1, 2'b11, 2'b11, 1'b1}); // re-offered to both
    vecs.push_back('{1'b1, 8'h7E, 1'b1, 2'b00, 2'b11, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0});

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r]);
      #1;
      checkOutput($sformatf("row%0d q_valid", r), 32'(qv2), 32'(vecs[r].qv));
      checkOutput($sformatf("row%0d d_bp", r), 32'(db2), 32'(vecs[r].dbp));
      checkOutput($sformatf("row%0d q", r), 32'(q2), 32'(vecs[r].d));
    end

    // ---------------- dut4 random scoreboard ----------------
    @(negedge clk);
    rstn_b = 1'b0;
    @(negedge clk);
    rstn_b = 1'b1;
    begin
      int  retired = 0;
      int  cycles  = 0;
      bit  have    = 1'b0;
      logic [7:0] e;
      while (retired < 1000 && cycles < 20000) begin
        @(negedge clk);
        cycles++;
        if (!have) begin
          if ($urandom_range(0, 9) < 8) begin
            d4   = 8'($urandom);
            dv4  = 1'b1;
            have = 1'b1;
            for (int i = 0; i < 4; i++) exp4[i].push_back(d4);
          end else begin
            dv4 = 1'b0;
          end
        end
        for (int i = 0; i < 4; i++) qbp4[i] = ($urandom_range(0, 9) < 3);
        #1;
        for (int i = 0; i < 4; i++) begin
          if (qv4[i] && !qbp4[i]) begin
            if (exp4[i].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL out%0d extra token: got %0h expected none", i, q4);
            end else begin
              e = exp4[i].pop_front();
              checkOutput($sformatf("out%0d token %0d", i, retired), 32'(q4), 32'(e));
            end
          end
        end
        if (dv4 && !db4) begin
          for (int i = 0; i < 4; i++)
            checkOutput($sformatf("out%0d pending at retire", i), exp4[i].size(), 0);
          retired++;
          have = 1'b0;
        end
      end
      checkOutput("tokens retired", retired, 1000);
      @(negedge clk);
      dv4  = 1'b0;
      qbp4 = '0;
    end

    // ---------------- dut1 degenerate wire ----------------
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      d1   = 8'($urandom);
      dv1  = 1'($urandom_range(0, 1));
      qbp1 = 1'($urandom_range(0, 1));
      #1;
      checkOutput($sformatf("n1 c%0d q_valid", c), 32'(qv1), 32'(dv1));
      checkOutput($sformatf("n1 c%0d d_bp", c), 32'(db1), 32'(dv1 & qbp1));
      checkOutput($sformatf("n1 c%0d q", c), 32'(q1), 32'(d1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
